rv32i_id_ex_stage: RTL and testbench
====================================

// Module: rv32i_id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the RV32IM core. Captures decoded instruction fields and control-unit outputs
//  at the end of ID and presents them to EX. Contains the load-use hazard detector: drives a stall to PC/IF-ID
//  and inserts a bubble into EX. Also handles flush (taken branch/jump resolved in EX) and a global hold.
//  Counts load-use bubbles for performance monitoring.
// PARAMETERS
//  XLEN        32  datapath width
//  REG_ADDR_W  5   register index width
//  CNT_W       32  bubble counter width
// PORTS
//  i_clk            in   1           clock, rising edge
//  i_rst            in   1           synchronous reset, active-high
//  i_valid          in   1           ID holds a real instruction
//  i_pc             in   XLEN        PC of ID instruction
//  i_rs1_data       in   XLEN        register-file read data, port 1
//  i_rs2_data       in   XLEN        register-file read data, port 2
//  i_imm            in   XLEN        sign-extended immediate
//  i_rs1_addr       in   REG_ADDR_W  source register index 1
//  i_rs2_addr       in   REG_ADDR_W  source register index 2
//  i_rd_addr        in   REG_ADDR_W  destination register index
//  i_rs1_used       in   1           instruction reads rs1
//  i_rs2_used       in   1           instruction reads rs2
//  i_funct3         in   3           funct3 field
//  i_funct7_5       in   1           funct7 bit 5
//  i_funct7_0       in   1           funct7 bit 0 (M-extension)
//  i_reg_write_en, i_mem_write_en, i_mem_read_en, i_mem_to_reg, i_alu_src_a
//                   in   1 each      control-unit outputs
//  i_alu_src_b      in   2           control-unit output
//  i_hold           in   1           global freeze (memory wait)
//  i_flush          in   1           kill the instruction entering EX
//  o_<field>        out  as input    registered copy of every i_<field> above except i_hold, i_flush, i_*_used
//  o_valid          out  1           EX holds a real instruction
//  o_stall_id       out  1           combinational; hold PC and IF/ID this cycle
//  o_bubble_cnt     out  CNT_W       load-use bubbles inserted, saturating
// BEHAVIOUR
//  Reset: every o_* register = 0, o_valid = 0, o_bubble_cnt = 0. Reset state is a bubble; ALU/MEM select
//    codes of 0 equal the control-unit defaults (REG/ALU).
//  Hazard (combinational): haz = o_valid & o_mem_read_en & (o_rd_addr != 0) & i_valid &
//    ((i_rs1_used & i_rs1_addr == o_rd_addr) | (i_rs2_used & i_rs2_addr == o_rd_addr)).
//  o_stall_id = haz & ~i_flush. Stall is never asserted while flushing. Upstream ORs i_hold itself.
//  Register update at rising edge, priority order:
//    1. i_rst  -> reset values.
//    2. i_hold -> all registers keep their value, counter included.
//       A flush or hazard under hold is not acted on. Requesters hold i_flush until i_hold drops.
//    3. i_flush -> bubble: all o_* = 0, o_valid = 0. Counter unchanged.
//    4. haz    -> bubble as in 3. o_bubble_cnt += 1, saturating at 2^CNT_W-1 with no wrap.
//    5. else   -> capture all i_* fields. o_valid = i_valid.
//       If i_valid = 0, all control enables are stored as 0.
//  Latency: 1 cycle ID->EX. A load-use pair costs exactly 1 bubble.
//    In the next cycle o_mem_read_en = 0, so haz clears and the dependent instruction advances.
//  rd = x0 never creates a hazard. A store reading a loaded register via rs2 does stall.
//  Data fields of a bubble are 0, not stale, so waveforms and EX comparisons stay deterministic.
// TESTING
//  T1 reset: hold i_rst 2 cycles with random inputs -> all outputs 0, o_stall_id = 0.
//  T2 capture: addi x3,x1,5 (pc=0x100, imm=5) -> next cycle o_valid=1, o_pc=0x100, o_imm=5, o_rd_addr=3,
//     o_alu_src_b=IMM, o_reg_write_en=1.
//  T3 load-use: lw x5 captured, then add x6,x5,x1 in ID -> o_stall_id=1 for one cycle, bubble, o_bubble_cnt=1.
//     Next cycle the add is captured with o_stall_id=0.
//  T4 x0/no-use: lw x0 then add x6,x0,x1 -> no stall. lw x5 then lui x5 (rs unused) -> no stall.
//  T5 flush+hazard same cycle -> o_stall_id=0, bubble, count unchanged. Hold+flush -> regs frozen,
//     flush acted on after hold drops.
//  T6 saturation: CNT_W=2, force 5 load-use hazards -> o_bubble_cnt stays 3.

Source files
------------

// File: rtl/rv32i_id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold; counts inserted bubbles.
// Latency 1 cycle ID->EX; o_stall_id backpressures PC/IF-ID combinationally, i_hold freezes all state.
module rv32i_id_ex_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [XLEN-1:0]       i_pc,
   input  logic [XLEN-1:0]       i_rs1_data,
   input  logic [XLEN-1:0]       i_rs2_data,
   input  logic [XLEN-1:0]       i_imm,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
   input  logic [REG_ADDR_W-1:0] i_rd_addr,
   input  logic                  i_rs1_used,
   input  logic                  i_rs2_used,
   input  logic [2:0]            i_funct3,
   input  logic                  i_funct7_5,
   input  logic                  i_funct7_0,
   input  logic                  i_reg_write_en,
   input  logic                  i_mem_write_en,
   input  logic                  i_mem_read_en,
   input  logic                  i_mem_to_reg,
   input  logic                  i_alu_src_a,
   input  logic [1:0]            i_alu_src_b,
   input  logic                  i_hold,
   input  logic                  i_flush,
   output logic                  o_valid,
   output logic [XLEN-1:0]       o_pc,
   output logic [XLEN-1:0]       o_rs1_data,
   output logic [XLEN-1:0]       o_rs2_data,
   output logic [XLEN-1:0]       o_imm,
   output logic [REG_ADDR_W-1:0] o_rs1_addr,
   output logic [REG_ADDR_W-1:0] o_rs2_addr,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic [2:0]            o_funct3,
   output logic                  o_funct7_5,
   output logic                  o_funct7_0,
   output logic                  o_reg_write_en,
   output logic                  o_mem_write_en,
   output logic                  o_mem_read_en,
   output logic                  o_mem_to_reg,
   output logic                  o_alu_src_a,
   output logic [1:0]            o_alu_src_b,
   output logic                  o_stall_id,
   output logic [CNT_W-1:0]      o_bubble_cnt
);

   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
      logic [XLEN-1:0]       imm;
      logic [REG_ADDR_W-1:0] rs1_addr;
      logic [REG_ADDR_W-1:0] rs2_addr;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic [2:0]            funct3;
      logic                  funct7_5;
      logic                  funct7_0;
      logic                  reg_write_en;
      logic                  mem_write_en;
      logic                  mem_read_en;
      logic                  mem_to_reg;
      logic                  alu_src_a;
      logic [1:0]            alu_src_b;
   } id_ex_t;

   id_ex_t           ex_q;
   id_ex_t           id_d;
   logic [CNT_W-1:0] bubble_cnt_q;
   logic             haz;

   // A non-valid ID slot keeps its data fields but must never write anything downstream.
   always_comb begin
      id_d              = '0;
      id_d.valid        = i_valid;
      id_d.pc           = i_pc;
      id_d.rs1_data     = i_rs1_data;
      id_d.rs2_data     = i_rs2_data;
      id_d.imm          = i_imm;
      id_d.rs1_addr     = i_rs1_addr;
      id_d.rs2_addr     = i_rs2_addr;
      id_d.rd_addr      = i_rd_addr;
      id_d.funct3       = i_funct3;
      id_d.funct7_5     = i_funct7_5;
      id_d.funct7_0     = i_funct7_0;
      id_d.alu_src_a    = i_alu_src_a;
      id_d.alu_src_b    = i_alu_src_b;
      id_d.reg_write_en = i_valid & i_reg_write_en;
      id_d.mem_write_en = i_valid & i_mem_write_en;
      id_d.mem_read_en  = i_valid & i_mem_read_en;
      id_d.mem_to_reg   = i_valid & i_mem_to_reg;
   end

   always_comb begin
      haz = ex_q.valid & ex_q.mem_read_en & (ex_q.rd_addr != '0) & i_valid &
            ((i_rs1_used & (i_rs1_addr == ex_q.rd_addr)) |
             (i_rs2_used & (i_rs2_addr == ex_q.rd_addr)));
   end

   assign o_stall_id = haz & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_q         <= '0;
         bubble_cnt_q <= '0;
      end else if (!i_hold) begin
         if (i_flush) begin
            ex_q <= '0;
         end else if (haz) begin
            ex_q <= '0;
            if (bubble_cnt_q != '1)
               bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
         end else begin
            ex_q <= id_d;
         end
      end
   end

   assign o_valid        = ex_q.valid;
   assign o_pc           = ex_q.pc;
   assign o_rs1_data     = ex_q.rs1_data;
   assign o_rs2_data     = ex_q.rs2_data;
   assign o_imm          = ex_q.imm;
   assign o_rs1_addr     = ex_q.rs1_addr;
   assign o_rs2_addr     = ex_q.rs2_addr;
   assign o_rd_addr      = ex_q.rd_addr;
   assign o_funct3       = ex_q.funct3;
   assign o_funct7_5     = ex_q.funct7_5;
   assign o_funct7_0     = ex_q.funct7_0;
   assign o_reg_write_en = ex_q.reg_write_en;
   assign o_mem_write_en = ex_q.mem_write_en;
   assign o_mem_read_en  = ex_q.mem_read_en;
   assign o_mem_to_reg   = ex_q.mem_to_reg;
   assign o_alu_src_a    = ex_q.alu_src_a;
   assign o_alu_src_b    = ex_q.alu_src_b;
   assign o_bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_rv32i_id_ex_stage.sv
// Directed bench for rv32i_id_ex_stage: default instance plus a CNT_W=2 instance sharing the same inputs.
module tb_rv32i_id_ex_stage;

   localparam logic [1:0] SRC_B_IMM = 2'd1;

   logic        clk = 1'b0;
   logic        rst, valid, hold, flush;
   logic [31:0] pc, rs1_data, rs2_data, imm;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rs1_used, rs2_used, funct7_5, funct7_0;
   logic [2:0]  funct3;
   logic        reg_write_en, mem_write_en, mem_read_en, mem_to_reg, alu_src_a;
   logic [1:0]  alu_src_b;

   logic        o_valid, o_funct7_5, o_funct7_0, o_reg_write_en, o_mem_write_en;
   logic        o_mem_read_en, o_mem_to_reg, o_alu_src_a, o_stall_id;
   logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm, o_bubble_cnt;
   logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
   logic [2:0]  o_funct3;
   logic [1:0]  o_alu_src_b;

   logic        s_valid, s_funct7_5, s_funct7_0, s_reg_write_en, s_mem_write_en;
   logic        s_mem_read_en, s_mem_to_reg, s_alu_src_a, s_stall_id;
   logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
   logic [1:0]  s_bubble_cnt;
   logic [4:0]  s_rs1_addr, s_rs2_addr, s_rd_addr;
   logic [2:0]  s_funct3;
   logic [1:0]  s_alu_src_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv32i_id_ex_stage dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc), .i_rs1_data(rs1_data),
      .i_rs2_data(rs2_data), .i_imm(imm), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .i_rd_addr(rd_addr), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used), .i_funct3(funct3),
      .i_funct7_5(funct7_5), .i_funct7_0(funct7_0), .i_reg_write_en(reg_write_en),
      .i_mem_write_en(mem_write_en), .i_mem_read_en(mem_read_en), .i_mem_to_reg(mem_to_reg),
      .i_alu_src_a(alu_src_a), .i_alu_src_b(alu_src_b), .i_hold(hold), .i_flush(flush),
      .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
      .o_imm(o_imm), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
      .o_funct3(o_funct3), .o_funct7_5(o_funct7_5), .o_funct7_0(o_funct7_0),
      .o_reg_write_en(o_reg_write_en), .o_mem_write_en(o_mem_write_en),
      .o_mem_read_en(o_mem_read_en), .o_mem_to_reg(o_mem_to_reg), .o_alu_src_a(o_alu_src_a),
      .o_alu_src_b(o_alu_src_b), .o_stall_id(o_stall_id), .o_bubble_cnt(o_bubble_cnt)
   );

   rv32i_id_ex_stage #(.CNT_W(2)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc), .i_rs1_data(rs1_data),
      .i_rs2_data(rs2_data), .i_imm(imm), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .i_rd_addr(rd_addr), .i_rs1_used(rs1_used), .i_rs2_used(rs2_used), .i_funct3(funct3),
      .i_funct7_5(funct7_5), .i_funct7_0(funct7_0), .i_reg_write_en(reg_write_en),
      .i_mem_write_en(mem_write_en), .i_mem_read_en(mem_read_en), .i_mem_to_reg(mem_to_reg),
      .i_alu_src_a(alu_src_a), .i_alu_src_b(alu_src_b), .i_hold(hold), .i_flush(flush),
      .o_valid(s_valid), .o_pc(s_pc), .o_rs1_data(s_rs1_data), .o_rs2_data(s_rs2_data),
      .o_imm(s_imm), .o_rs1_addr(s_rs1_addr), .o_rs2_addr(s_rs2_addr), .o_rd_addr(s_rd_addr),
      .o_funct3(s_funct3), .o_funct7_5(s_funct7_5), .o_funct7_0(s_funct7_0),
      .o_reg_write_en(s_reg_write_en), .o_mem_write_en(s_mem_write_en),
      .o_mem_read_en(s_mem_read_en), .o_mem_to_reg(s_mem_to_reg), .o_alu_src_a(s_alu_src_a),
      .o_alu_src_b(s_alu_src_b), .o_stall_id(s_stall_id), .o_bubble_cnt(s_bubble_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_instr(input logic [31:0] ipc, input logic [31:0] iimm,
                           input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                           input logic u1, input logic u2, input logic rw, input logic mr,
                           input logic mw, input logic [1:0] srcb);
      valid = 1'b1; pc = ipc; imm = iimm;
      rs1_addr = a1; rs2_addr = a2; rd_addr = ad; rs1_used = u1; rs2_used = u2;
      reg_write_en = rw; mem_read_en = mr; mem_to_reg = mr; mem_write_en = mw;
      alu_src_b = srcb; alu_src_a = 1'b0;
      rs1_data = 32'h11; rs2_data = 32'h22; funct3 = 3'd0; funct7_5 = 1'b0; funct7_0 = 1'b0;
      #1;
   endtask

   initial begin
      // T1: reset with random inputs
      rst = 1'b1;
      {valid, hold, flush, rs1_used, rs2_used, funct7_5, funct7_0} = 7'($urandom);
      {reg_write_en, mem_write_en, mem_read_en, mem_to_reg, alu_src_a} = 5'($urandom);
      pc = $urandom; rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
      {rs1_addr, rs2_addr, rd_addr, funct3, alu_src_b} = 20'($urandom);
      step();
      step();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_pc", o_pc, 32'd0);
      chk("rst_rs1_data", o_rs1_data, 32'd0);
      chk("rst_rd", 32'(o_rd_addr), 32'd0);
      chk("rst_mem_read", 32'(o_mem_read_en), 32'd0);
      chk("rst_cnt", o_bubble_cnt, 32'd0);
      chk("rst_stall", 32'(o_stall_id), 32'd0);
      rst = 1'b0; hold = 1'b0; flush = 1'b0;

      // T2: addi x3,x1,5
      id_instr(32'h100, 32'd5, 5'd1, 5'd0, 5'd3, 1, 0, 1, 0, 0, SRC_B_IMM);
      step();
      chk("addi_valid", 32'(o_valid), 32'd1);
      chk("addi_pc", o_pc, 32'h100);
      chk("addi_imm", o_imm, 32'd5);
      chk("addi_rd", 32'(o_rd_addr), 32'd3);
      chk("addi_srcb", 32'(o_alu_src_b), 32'(SRC_B_IMM));
      chk("addi_rw", 32'(o_reg_write_en), 32'd1);
      chk("addi_rs1_data", o_rs1_data, 32'h11);

      // T3: lw x5 then add x6,x5,x1
      id_instr(32'h104, 32'd0, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, SRC_B_IMM);
      chk("lw_nostall", 32'(o_stall_id), 32'd0);
      step();
      id_instr(32'h108, 32'd0, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0, 2'd0);
      chk("lu_stall", 32'(o_stall_id), 32'd1);
      step();
      chk("lu_bubble_valid", 32'(o_valid), 32'd0);
      chk("lu_bubble_pc", o_pc, 32'd0);
      chk("lu_bubble_rd", 32'(o_rd_addr), 32'd0);
      chk("lu_cnt", o_bubble_cnt, 32'd1);
      chk("lu_stall_clear", 32'(o_stall_id), 32'd0);
      step();
      chk("lu_add_valid", 32'(o_valid), 32'd1);
      chk("lu_add_pc", o_pc, 32'h108);
      chk("lu_add_rd", 32'(o_rd_addr), 32'd6);
      chk("lu_cnt_after", o_bubble_cnt, 32'd1);

      // T4: lw x0 / add using x0; lw x5 / lui x5; lw x7 / sw x7 via rs2
      id_instr(32'h10c, 32'd0, 5'd2, 5'd0, 5'd0, 1, 0, 1, 1, 0, SRC_B_IMM);
      step();
      id_instr(32'h110, 32'd0, 5'd0, 5'd1, 5'd6, 1, 1, 1, 0, 0, 2'd0);
      chk("x0_nostall", 32'(o_stall_id), 32'd0);
      step();
      chk("x0_add_pc", o_pc, 32'h110);
      id_instr(32'h114, 32'd0, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, SRC_B_IMM);
      step();
      id_instr(32'h118, 32'h5000, 5'd5, 5'd5, 5'd5, 0, 0, 1, 0, 0, SRC_B_IMM);
      chk("lui_nostall", 32'(o_stall_id), 32'd0);
      step();
      chk("lui_pc", o_pc, 32'h118);
      id_instr(32'h11c, 32'd0, 5'd2, 5'd0, 5'd7, 1, 0, 1, 1, 0, SRC_B_IMM);
      step();
      id_instr(32'h120, 32'd4, 5'd2, 5'd7, 5'd0, 1, 1, 0, 0, 1, SRC_B_IMM);
      chk("sw_rs2_stall", 32'(o_stall_id), 32'd1);
      step();
      chk("sw_bubble_valid", 32'(o_valid), 32'd0);
      chk("sw_cnt", o_bubble_cnt, 32'd2);
      step();
      chk("sw_mem_write", 32'(o_mem_write_en), 32'd1);
      chk("sw_pc", o_pc, 32'h120);

      // Invalid ID slot: fields captured, enables forced to 0
      id_instr(32'h124, 32'd0, 5'd1, 5'd0, 5'd9, 1, 0, 1, 1, 1, SRC_B_IMM);
      valid = 1'b0;
      step();
      chk("inv_valid", 32'(o_valid), 32'd0);
      chk("inv_pc", o_pc, 32'h124);
      chk("inv_rw", 32'(o_reg_write_en), 32'd0);
      chk("inv_mr", 32'(o_mem_read_en), 32'd0);

      // T5: flush with simultaneous hazard
      id_instr(32'h200, 32'd0, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, SRC_B_IMM);
      step();
      id_instr(32'h204, 32'd0, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0, 2'd0);
      flush = 1'b1; #1;
      chk("flush_nostall", 32'(o_stall_id), 32'd0);
      step();
      chk("flush_valid", 32'(o_valid), 32'd0);
      chk("flush_pc", o_pc, 32'd0);
      chk("flush_cnt", o_bubble_cnt, 32'd2);
      // Hold + flush: frozen, flush applied once hold drops
      flush = 1'b0;
      id_instr(32'h208, 32'd0, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, SRC_B_IMM);
      step();
      id_instr(32'h20c, 32'd0, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0, 2'd0);
      hold = 1'b1; flush = 1'b1; #1;
      step();
      step();
      chk("hold_pc", o_pc, 32'h208);
      chk("hold_mr", 32'(o_mem_read_en), 32'd1);
      hold = 1'b0; #1;
      step();
      chk("hold_flush_valid", 32'(o_valid), 32'd0);
      chk("hold_flush_cnt", o_bubble_cnt, 32'd2);
      // Hold + hazard: stall visible, counter frozen until hold drops
      flush = 1'b0;
      id_instr(32'h210, 32'd0, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, SRC_B_IMM);
      step();
      id_instr(32'h214, 32'd0, 5'd1, 5'd5, 5'd6, 1, 1, 1, 0, 0, 2'd0);
      hold = 1'b1; #1;
      chk("hold_haz_stall", 32'(o_stall_id), 32'd1);
      step();
      chk("hold_haz_cnt", o_bubble_cnt, 32'd2);
      chk("hold_haz_pc", o_pc, 32'h210);
      hold = 1'b0; #1;
      step();
      chk("haz_after_hold_cnt", o_bubble_cnt, 32'd3);
      chk("sat_cnt3", 32'(s_bubble_cnt), 32'd3);
      step();
      chk("haz_after_hold_pc", o_pc, 32'h214);

      // T6: two more load-use pairs saturate the 2-bit counter
      for (int k = 0; k < 2; k++) begin
         id_instr(32'h300 + 32'(8 * k), 32'd0, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, SRC_B_IMM);
         step();
         id_instr(32'h304 + 32'(8 * k), 32'd0, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0, 2'd0);
         step();
         step();
      end
      chk("cnt_total", o_bubble_cnt, 32'd5);
      chk("sat_cnt", 32'(s_bubble_cnt), 32'd3);
      chk("sat_valid", 32'(s_valid), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
